// File: rtl/cic_decimator.sv
// N-stage CIC decimator (M = 1), R = 2^dec_log2, power-of-two gain removal with round-half-up and saturation.
// Latency 1 clk from the strobing input; no backpressure. Optional saturation counter under CIC_SAT_CNT_EN.
module cic_decimator #(
    parameter int DATA_WIDTH   = 16,
    parameter int DATA_FRAC    = 15,
    parameter int N_STAGES     = 5,
    parameter int MAX_DEC_LOG2 = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef CIC_SAT_CNT_EN
    input  logic                         sat_cnt_clr,
    output logic [15:0]                  sat_count,
`endif
    input  logic                         valid_in,
    input  logic                         bypass,
    input  logic [2:0]                   dec_log2,
    input  logic signed [DATA_WIDTH-1:0] cic_in,
    output logic signed [DATA_WIDTH-1:0] cic_out,
    output logic                         valid_out,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int ACC_WIDTH = DATA_WIDTH + N_STAGES * MAX_DEC_LOG2;
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((2 ** DATA_FRAC) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = -SAT_HI - 1;
    localparam logic signed [ACC_WIDTH-1:0] ONE = ACC_WIDTH'(1);

    logic signed [ACC_WIDTH-1:0] integ [N_STAGES];
    logic signed [ACC_WIDTH-1:0] dly   [N_STAGES];
    logic signed [ACC_WIDTH-1:0] c     [N_STAGES+1];
    logic signed [ACC_WIDTH-1:0] in_ext;
    logic signed [ACC_WIDTH-1:0] rnd;
    logic signed [ACC_WIDTH-1:0] scaled;
    logic [MAX_DEC_LOG2-1:0]     cnt;
    logic [MAX_DEC_LOG2-1:0]     cnt_max;
    logic [2:0]                  dec_lat;
    logic [2:0]                  dec_clamped;
    logic [7:0]                  sh;
    logic                        bypass_q;
    logic                        flush;
    logic                        strobe;
    logic                        sat_hi;
    logic                        sat_lo;
    logic [DATA_WIDTH-1:0]       res_dat;

    always_comb begin
        dec_clamped = (dec_log2 > 3'(MAX_DEC_LOG2)) ? 3'(MAX_DEC_LOG2) : dec_log2;
        // A new rate or leaving bypass restarts the filter from zero state.
        flush   = (dec_clamped != dec_lat) || (bypass_q && !bypass);
        cnt_max = MAX_DEC_LOG2'((32'd1 << dec_lat) - 32'd1);
        strobe  = !flush && !bypass && valid_in && (cnt == cnt_max);
        in_ext  = {{(ACC_WIDTH-DATA_WIDTH){cic_in[DATA_WIDTH-1]}}, cic_in};
        sh      = 8'(N_STAGES * dec_lat);

        c[0] = integ[N_STAGES-1];
        for (int k = 1; k <= N_STAGES; k++) begin
            c[k] = c[k-1] - dly[k-1];
        end

        rnd = '0;
        if (sh != 8'd0) begin
            rnd = ONE << (sh - 8'd1);
        end
        scaled = (c[N_STAGES] + rnd) >>> sh;
        sat_hi = scaled > SAT_HI;
        sat_lo = scaled < SAT_LO;
        if (sat_hi) begin
            res_dat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (sat_lo) begin
            res_dat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            res_dat = scaled[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_STAGES; k++) begin
                integ[k] <= '0;
                dly[k]   <= '0;
            end
            cnt       <= '0;
            dec_lat   <= '0;
            bypass_q  <= 1'b0;
            cic_out   <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            bypass_q  <= bypass;
            if (flush) begin
                dec_lat <= dec_clamped;
                cnt     <= '0;
                for (int k = 0; k < N_STAGES; k++) begin
                    integ[k] <= '0;
                    dly[k]   <= '0;
                end
            end else if (bypass) begin
                if (valid_in) begin
                    cic_out   <= cic_in;
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                    valid_out <= 1'b1;
                end
            end else if (valid_in) begin
                // Each stage adds its pre-update neighbour, so the chain is pipelined.
                integ[0] <= integ[0] + in_ext;
                for (int k = 1; k < N_STAGES; k++) begin
                    integ[k] <= integ[k] + integ[k-1];
                end
                if (strobe) begin
                    cnt <= '0;
                    for (int k = 0; k < N_STAGES; k++) begin
                        dly[k] <= c[k];
                    end
                    cic_out   <= res_dat;
                    overflow  <= sat_hi;
                    underflow <= sat_lo;
                    valid_out <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef CIC_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (sat_cnt_clr) begin
            sat_count <= '0;
        end else if (strobe && (sat_hi || sat_lo) && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule
